adder_stream_fifo: RTL

- Parametrised successor of the team's 8-bit valid/ready adder.
- Adds or subtracts two WIDTH-bit operands per accepted input transaction and queues each result in a DEPTH-entry output FIFO.
- Sustains one transaction per cycle and tolerates downstream stalls without dropping data.
- Sits between an operand producer and a result consumer, both on valid/ready streams.

---
 rtl/adder_stream_fifo.sv | 92 +++++++++
 1 files changed

// File: rtl/adder_stream_fifo.sv
// Streaming add/subtract unit. Each accepted operand pair produces a WIDTH+1 bit result,
// which is held in a DEPTH-entry FIFO until the consumer takes it.
module adder_stream_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             valid_i,
    output logic             ready_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             op_i,
    output logic             valid_o,
    input  logic             ready_o,
    output logic [WIDTH:0]   data_out_o,
    output logic [CW-1:0]    count_o
);

    localparam int unsigned   PW        = $clog2(DEPTH);
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);
    localparam logic [PW-1:0] LastPtr   = PW'(DEPTH - 1);

    logic [WIDTH:0]  mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [WIDTH:0]  opnd_a, opnd_b, result;
    logic            full, empty, push, pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PW'(1);
    endfunction

    // Zero-extension makes the MSB carry-out for add and borrow for subtract.
    always_comb begin
        opnd_a = {1'b0, data1_i};
        opnd_b = {1'b0, data2_i};
        result = op_i ? (opnd_a - opnd_b) : (opnd_a + opnd_b);
    end

    always_comb begin
        full    = (count_q == FullCount);
        empty   = (count_q == '0);
        ready_i = rstn && !full;
        valid_o = rstn && !empty;
        push    = valid_i && ready_i;
        pop     = valid_o && ready_o;
        count_o = rstn ? count_q : '0;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ptr_next(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; entries are only observed once the count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= result;
        end
    end

    assign data_out_o = mem_q[rd_ptr_q];

endmodule
